// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central hazard / flush / interrupt controller for the 5-stage core.
//   - Detects load-use hazards between the load in EX and the operands of ID.
//   - Squashes the ID->EX register on a taken branch, on interrupt entry and
//     on interrupt return.
//   - Sequences interrupt entry (redirect to IRQ_VECTOR, save EPC) and return
//     (rti in EX redirects to EPC) through a RUN / IRQ_WAIT / ISR state machine.
//
// Ports
//   clk, rst                  core clock, synchronous active-high reset
//   stall_mem                 memory stall, freezes all controller state
//   read_register1_if_id      rs1 of the instruction in ID
//   read_register2_if_id      rs2 of the instruction in ID
//   rd_en_ex                  instruction in EX is a load
//   write_reg_ex              rd of the instruction in EX
//   bj_inst_ex                branch/jump code in EX (0 = none)
//   branch_taken_ex           EX resolved a taken branch/jump this cycle
//   interrupt_branch_alert    ID holds a branch/jalr
//   rti_ex                    rti instruction in EX
//   pc_id                     PC of the instruction in ID
//   irq                       level interrupt request
//   hazard                    load-use stall to decode/fetch
//   flush                     squash the ID->EX register
//   pc_redirect, redirect_pc  fetch loads redirect_pc on the next edge
//   irq_ack                   one-cycle pulse on interrupt entry
//   in_isr                    interrupt handler active (irq masked)
//   epc                       saved return PC

module pipeline_ctrl #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] IRQ_VECTOR = 'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_mem,
  input  logic [4:0]      read_register1_if_id,
  input  logic [4:0]      read_register2_if_id,
  input  logic            rd_en_ex,
  input  logic [4:0]      write_reg_ex,
  input  logic [3:0]      bj_inst_ex,
  input  logic            branch_taken_ex,
  input  logic            interrupt_branch_alert,
  input  logic            rti_ex,
  input  logic [PC_W-1:0] pc_id,
  input  logic            irq,
  output logic            hazard,
  output logic            flush,
  output logic            pc_redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            irq_ack,
  output logic            in_isr,
  output logic [PC_W-1:0] epc
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IRQ_WAIT = 2'd1,
    ISR      = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            inIsr_q;
  logic            irqPend_q;
  logic [PC_W-1:0] epc_q;

  logic loadUse;
  logic irqTake;
  logic rtiTake;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign loadUse = rd_en_ex && (write_reg_ex != 5'd0) &&
                   ((write_reg_ex == read_register1_if_id) ||
                    (write_reg_ex == read_register2_if_id));

  // Interrupt entry waits for a quiet pipeline: no control transfer in ID or
  // EX and no load-use stall, so the PC saved from ID is the true resume point.
  assign irqTake = !rst && (state_q == IRQ_WAIT) && !interrupt_branch_alert &&
                   (bj_inst_ex == 4'd0) && !branch_taken_ex && !loadUse &&
                   !stall_mem;

  // A taken branch owns the fetch redirect, so it outranks the rti redirect.
  assign rtiTake = !rst && (state_q == ISR) && rti_ex && !stall_mem &&
                   !branch_taken_ex;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a memory stall freezes the sequencer in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!stall_mem && (irqPend_q || (irq && !inIsr_q))) begin
          state_d = IRQ_WAIT;
        end
      end
      IRQ_WAIT: begin
        if (irqTake) begin
          state_d = ISR;
        end
      end
      ISR: begin
        if (rtiTake) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs. The flush from a redirect suppresses the hazard, because the
  // squashed ID instruction no longer needs to wait for the load.
  always_comb begin
    hazard      = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    irq_ack     = 1'b0;
    if (!rst) begin
      flush = branch_taken_ex || irqTake || rtiTake;
      if (irqTake) begin
        pc_redirect = 1'b1;
        redirect_pc = IRQ_VECTOR;
        irq_ack     = 1'b1;
      end else if (rtiTake) begin
        pc_redirect = 1'b1;
        redirect_pc = epc_q;
      end
      hazard = loadUse && !flush;
    end
  end

  // Interrupt bookkeeping. Entry clears the pending flag even if irq is still
  // high; while in the handler new requests are ignored (no nesting).
  always_ff @(posedge clk) begin
    if (rst) begin
      inIsr_q   <= 1'b0;
      irqPend_q <= 1'b0;
      epc_q     <= '0;
    end else if (!stall_mem) begin
      if (irqTake) begin
        epc_q     <= pc_id;
        inIsr_q   <= 1'b1;
        irqPend_q <= 1'b0;
      end else begin
        if (rtiTake) begin
          inIsr_q <= 1'b0;
        end
        if (irq && !inIsr_q) begin
          irqPend_q <= 1'b1;
        end
      end
    end
  end

  assign in_isr = inIsr_q;
  assign epc    = epc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed-vector bench for pipeline_ctrl. Inputs change 1 ns after a rising
//   edge and outputs are sampled 1 ns later, well clear of the next edge.

module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem;
  logic [4:0]  read_register1_if_id;
  logic [4:0]  read_register2_if_id;
  logic        rd_en_ex;
  logic [4:0]  write_reg_ex;
  logic [3:0]  bj_inst_ex;
  logic        branch_taken_ex;
  logic        interrupt_branch_alert;
  logic        rti_ex;
  logic [31:0] pc_id;
  logic        irq;
  logic        hazard;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        irq_ack;
  logic        in_isr;
  logic [31:0] epc;

  int vecCount = 0;
  int missCount = 0;

  pipeline_ctrl #(.PC_W(32), .IRQ_VECTOR(32'h0000_0100)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall_mem             (stall_mem),
    .read_register1_if_id  (read_register1_if_id),
    .read_register2_if_id  (read_register2_if_id),
    .rd_en_ex              (rd_en_ex),
    .write_reg_ex          (write_reg_ex),
    .bj_inst_ex            (bj_inst_ex),
    .branch_taken_ex       (branch_taken_ex),
    .interrupt_branch_alert(interrupt_branch_alert),
    .rti_ex                (rti_ex),
    .pc_id                 (pc_id),
    .irq                   (irq),
    .hazard                (hazard),
    .flush                 (flush),
    .pc_redirect           (pc_redirect),
    .redirect_pc           (redirect_pc),
    .irq_ack               (irq_ack),
    .in_isr                (in_isr),
    .epc                   (epc)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive every input to its quiet value.
  task automatic applyStimulus();
    stall_mem              = 1'b0;
    read_register1_if_id   = 5'd0;
    read_register2_if_id   = 5'd0;
    rd_en_ex               = 1'b0;
    write_reg_ex           = 5'd0;
    bj_inst_ex             = 4'd0;
    branch_taken_ex        = 1'b0;
    interrupt_branch_alert = 1'b0;
    rti_ex                 = 1'b0;
    pc_id                  = 32'h0;
    irq                    = 1'b0;
  endtask

  // Advance one clock, leaving time 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    applyStimulus();
    rst = 1'b1;
    tick();
    tick();

    // Reset: combinational outputs forced low even with active triggers.
    rd_en_ex = 1'b1; write_reg_ex = 5'd5; read_register2_if_id = 5'd5;
    branch_taken_ex = 1'b1; irq = 1'b1;
    settle();
    checkOutput("rst_hazard", hazard, 0);
    checkOutput("rst_flush", flush, 0);
    checkOutput("rst_redirect", pc_redirect, 0);
    checkOutput("rst_in_isr", in_isr, 0);
    checkOutput("rst_epc", epc, 0);
    applyStimulus();
    tick();
    rst = 1'b0;
    tick();

    // Load-use hazards.
    rd_en_ex = 1'b1; write_reg_ex = 5'd5;
    read_register1_if_id = 5'd3; read_register2_if_id = 5'd5;
    settle();
    checkOutput("lu_rs2", hazard, 1);
    checkOutput("lu_rs2_flush", flush, 0);
    tick();
    write_reg_ex = 5'd0; read_register1_if_id = 5'd0; read_register2_if_id = 5'd0;
    settle();
    checkOutput("lu_x0", hazard, 0);
    tick();
    write_reg_ex = 5'd7; read_register1_if_id = 5'd7; read_register2_if_id = 5'd1;
    settle();
    checkOutput("lu_rs1", hazard, 1);
    tick();
    rd_en_ex = 1'b0;
    settle();
    checkOutput("no_load", hazard, 0);
    tick();

    // Taken branch beats load-use.
    rd_en_ex = 1'b1; write_reg_ex = 5'd9; read_register2_if_id = 5'd9;
    branch_taken_ex = 1'b1; bj_inst_ex = 4'd2;
    settle();
    checkOutput("br_flush", flush, 1);
    checkOutput("br_hazard", hazard, 0);
    checkOutput("br_no_redirect", pc_redirect, 0);
    applyStimulus();
    tick();

    // Interrupt entry: latch edge, then take in IRQ_WAIT.
    irq = 1'b1; pc_id = 32'h40;
    settle();
    checkOutput("irq_c0_ack", irq_ack, 0);
    tick();
    checkOutput("irq_take_ack", irq_ack, 1);
    checkOutput("irq_take_redir", pc_redirect, 1);
    checkOutput("irq_take_pc", redirect_pc, 32'h100);
    checkOutput("irq_take_flush", flush, 1);
    tick();
    checkOutput("irq_in_isr", in_isr, 1);
    checkOutput("irq_epc", epc, 32'h40);
    checkOutput("irq_ack_pulse", irq_ack, 0);
    checkOutput("isr_redir_idle", redirect_pc, 0);

    // irq pulses inside the handler are ignored.
    irq = 1'b0; tick();
    irq = 1'b1; settle();
    checkOutput("isr_irq_ack", irq_ack, 0);
    tick();
    irq = 1'b0; pc_id = 32'h80; rti_ex = 1'b1;
    settle();
    checkOutput("rti_redir", pc_redirect, 1);
    checkOutput("rti_pc", redirect_pc, 32'h40);
    checkOutput("rti_flush", flush, 1);
    checkOutput("rti_ack", irq_ack, 0);
    tick();
    rti_ex = 1'b0;
    settle();
    checkOutput("rti_in_isr", in_isr, 0);
    tick();
    checkOutput("rti_no_reentry1", irq_ack, 0);
    tick();
    checkOutput("rti_no_reentry2", irq_ack, 0);

    // Re-entry with irq held high across rti.
    irq = 1'b1; pc_id = 32'h44;
    tick();
    checkOutput("re_take1", irq_ack, 1);
    tick();
    checkOutput("re_epc1", epc, 32'h44);
    rti_ex = 1'b1;
    settle();
    checkOutput("re_rti_pc", redirect_pc, 32'h44);
    tick();
    rti_ex = 1'b0; pc_id = 32'h60;
    settle();
    checkOutput("re_r1_ack", irq_ack, 0);
    checkOutput("re_r1_isr", in_isr, 0);
    tick();
    checkOutput("re_r2_ack", irq_ack, 1);
    checkOutput("re_r2_pc", redirect_pc, 32'h100);
    tick();
    checkOutput("re_epc2", epc, 32'h60);
    checkOutput("re_isr2", in_isr, 1);

    // Reset mid-handler.
    irq = 1'b0; rst = 1'b1;
    tick();
    checkOutput("rst_mid_isr", in_isr, 0);
    checkOutput("rst_mid_epc", epc, 0);
    rst = 1'b0;
    tick();
    checkOutput("rst_mid_noack", irq_ack, 0);
    tick();
    checkOutput("rst_mid_noack2", irq_ack, 0);

    // Branch alert, then branch in EX, then load-use all block the take.
    irq = 1'b1; interrupt_branch_alert = 1'b1; pc_id = 32'h50;
    settle();
    checkOutput("al_c0", irq_ack, 0);
    tick();
    checkOutput("al_c1", irq_ack, 0);
    tick();
    checkOutput("al_c2", irq_ack, 0);
    tick();
    interrupt_branch_alert = 1'b0; bj_inst_ex = 4'd3; irq = 1'b0;
    settle();
    checkOutput("al_bj", irq_ack, 0);
    tick();
    bj_inst_ex = 4'd0; rd_en_ex = 1'b1; write_reg_ex = 5'd4; read_register1_if_id = 5'd4;
    settle();
    checkOutput("al_lu_ack", irq_ack, 0);
    checkOutput("al_lu_hazard", hazard, 1);
    tick();
    rd_en_ex = 1'b0;
    settle();
    checkOutput("al_take", irq_ack, 1);
    checkOutput("al_take_pc", redirect_pc, 32'h100);
    tick();
    checkOutput("al_epc", epc, 32'h50);

    // rti held off by a memory stall.
    rti_ex = 1'b1; stall_mem = 1'b1;
    settle();
    checkOutput("st_rti_redir", pc_redirect, 0);
    checkOutput("st_rti_flush", flush, 0);
    tick();
    checkOutput("st_rti_isr", in_isr, 1);
    stall_mem = 1'b0;
    settle();
    checkOutput("st_rti_go", pc_redirect, 1);
    checkOutput("st_rti_pc", redirect_pc, 32'h50);
    tick();
    rti_ex = 1'b0;
    settle();
    checkOutput("st_rti_done", in_isr, 0);

    // Interrupt entry held off by a memory stall; hazard stays live.
    irq = 1'b1; pc_id = 32'h70;
    tick();
    stall_mem = 1'b1; rd_en_ex = 1'b1; write_reg_ex = 5'd6; read_register2_if_id = 5'd6;
    settle();
    checkOutput("st_irq_ack", irq_ack, 0);
    checkOutput("st_irq_redir", pc_redirect, 0);
    checkOutput("st_irq_pc", redirect_pc, 0);
    checkOutput("st_hazard", hazard, 1);
    tick();
    checkOutput("st_irq_hold", irq_ack, 0);
    stall_mem = 1'b0; rd_en_ex = 1'b0;
    settle();
    checkOutput("st_irq_go", irq_ack, 1);
    tick();
    checkOutput("st_irq_epc", epc, 32'h70);
    checkOutput("st_irq_isr", in_isr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
